// File: rtl/ras_ctrl_pkg.sv
// Shared return-address-stack definitions: default geometry and the
// checkpoint record the branch unit can carry alongside a speculative branch.
package ras_ctrl_pkg;

    localparam int RAS_DEPTH = 4;
    localparam int RAS_VLEN  = 64;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    // Snapshot of the stack top pointer and occupancy at checkpoint time.
    typedef struct packed {
        logic [RAS_PTR_W-1:0] tp;
        logic [RAS_CNT_W-1:0] cnt;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ctrl_if.sv
// Request/response bundle between the decode/branch path and the RAS controller.
interface ras_ctrl_if
    import ras_ctrl_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int VLEN  = RAS_VLEN
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             push_i;
    logic [VLEN-1:0]  push_addr_i;
    logic             pop_i;
    logic             ckpt_i;
    logic             restore_i;
    logic             top_valid_o;
    logic [VLEN-1:0]  top_addr_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output flush_i, push_i, push_addr_i, pop_i, ckpt_i, restore_i,
        input  top_valid_o, top_addr_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, push_addr_i, pop_i, ckpt_i, restore_i,
        output top_valid_o, top_addr_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_ctrl_chk.sv
// Run-time property checks for the RAS controller (simulation only).
module ras_ctrl_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    input logic [$clog2(DEPTH):0]   cnt,
    input logic                     ckpt,
    input logic                     restore,
    input logic                     overflow,
    input logic                     underflow
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic ckpt_seen_r;

    // Remember whether any checkpoint has been taken since reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ckpt_seen_r <= 1'b0;
        end else if (ckpt) begin
            ckpt_seen_r <= 1'b1;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt <= CNT_W'(DEPTH));

    a_restore_first_ckpt: assert property (@(posedge clk_i) disable iff (rst_i)
        !(restore && ckpt && !ckpt_seen_r));

    a_flags_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(overflow && underflow));
endmodule

// File: rtl/ras_ctrl_mem.sv
// RAS entry storage: DEPTH x VLEN registers, one write port, one async read port.
module ras_ctrl_mem #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [VLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [VLEN-1:0]          rdata
);
    logic [VLEN-1:0] mem_r [DEPTH];

    // Entry registers: cleared on reset, one entry written per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {VLEN{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/ras_ctrl.sv
// Circular return-address-stack controller: top pointer, occupancy,
// speculative checkpoint/restore and flush, around a small entry array.
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int VLEN  = RAS_VLEN
) (
    input logic       clk_i,
    input logic       rst_i,
    ras_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] tp_r, tp_s, ckpt_tp_r, ckpt_tp_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, ckpt_cnt_r, ckpt_cnt_s;
    logic             we_s;
    logic [PTR_W-1:0] waddr_s;
    logic             ovf_s, unf_s;
    logic [VLEN-1:0]  rdata_s;
    logic             full_s, empty_s;

    assign full_s  = (cnt_r == CNT_W'(DEPTH));
    assign empty_s = (cnt_r == {CNT_W{1'b0}});

    ras_ctrl_mem #(.DEPTH(DEPTH), .VLEN(VLEN)) u_mem (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (bus.push_addr_i),
        .raddr (tp_r),
        .rdata (rdata_s)
    );

    // Next-state and flag decode; flush beats restore beats push/pop.
    always_comb begin
        tp_s       = tp_r;
        cnt_s      = cnt_r;
        ckpt_tp_s  = ckpt_tp_r;
        ckpt_cnt_s = ckpt_cnt_r;
        we_s       = 1'b0;
        waddr_s    = tp_r;
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        if (bus.flush_i) begin
            tp_s       = {PTR_W{1'b0}};
            cnt_s      = {CNT_W{1'b0}};
            ckpt_tp_s  = {PTR_W{1'b0}};
            ckpt_cnt_s = {CNT_W{1'b0}};
        end else if (bus.restore_i) begin
            // Entries are not rolled back; overwritten slots stay stale.
            tp_s  = ckpt_tp_r;
            cnt_s = ckpt_cnt_r;
        end else begin
            if (bus.ckpt_i) begin
                ckpt_tp_s  = tp_r;
                ckpt_cnt_s = cnt_r;
            end else begin
                ckpt_tp_s  = ckpt_tp_r;
                ckpt_cnt_s = ckpt_cnt_r;
            end
            case ({bus.push_i, bus.pop_i})
                2'b10: begin
                    tp_s    = tp_r + PTR_W'(1);
                    we_s    = 1'b1;
                    waddr_s = tp_r + PTR_W'(1);
                    if (full_s) begin
                        ovf_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (empty_s) begin
                        unf_s = 1'b1;
                    end else begin
                        tp_s  = tp_r - PTR_W'(1);
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Return-then-call: replace the top in place.
                    we_s    = 1'b1;
                    waddr_s = tp_r;
                    if (empty_s) begin
                        cnt_s = CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    tp_s  = tp_r;
                    cnt_s = cnt_r;
                end
            endcase
        end
    end

    // Pointer, occupancy and checkpoint registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp_r       <= {PTR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ckpt_tp_r  <= {PTR_W{1'b0}};
            ckpt_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tp_r       <= tp_s;
            cnt_r      <= cnt_s;
            ckpt_tp_r  <= ckpt_tp_s;
            ckpt_cnt_r <= ckpt_cnt_s;
        end
    end

    assign bus.top_addr_o  = rdata_s;
    assign bus.top_valid_o = !empty_s;
    assign bus.count_o     = cnt_r;
    assign bus.overflow_o  = ovf_s;
    assign bus.underflow_o = unf_s;

    ras_ctrl_chk #(.DEPTH(DEPTH)) u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cnt       (cnt_r),
        .ckpt      (bus.ckpt_i),
        .restore   (bus.restore_i),
        .overflow  (ovf_s),
        .underflow (unf_s)
    );
endmodule
